// File: rtl/knn_topk_engine.sv
// rtl/knn_topk_engine.sv - k-nearest-neighbour classifier with sorted top-K buffer and class vote
module knn_topk_engine #(
  parameter int DW       = 8,
  parameter int N_POINTS = 64,
  parameter int AW       = 6,
  parameter int KMAX     = 7,
  parameter int CW       = 1,
  parameter int LAT_W    = 8
) (
  input  logic             i_clk,
  input  logic             i_reset,
  input  logic             i_start,
  input  logic [3:0]       i_k_sel,
  input  logic             i_dist_mode,
  input  logic [DW-1:0]    i_query_x,
  input  logic [DW-1:0]    i_query_y,
  output logic [AW-1:0]    o_rom_addr,
  input  logic [DW-1:0]    i_rom_x,
  input  logic [DW-1:0]    i_rom_y,
  input  logic [CW-1:0]    i_rom_label,
  output logic             o_busy,
  output logic             o_done,
  output logic [CW-1:0]    o_pred_class,
  output logic             o_tie,
  output logic [LAT_W-1:0] o_latency
);
  localparam int NC     = 2**CW;
  localparam int DIST_W = 2*DW + 3;
  localparam int VW     = $clog2(KMAX + 1);
  localparam int IW     = $clog2(KMAX + 1);
  localparam int CNT_W  = 16;
  localparam logic [DW:0] ONE_D = 1;

  typedef enum logic [2:0] {S_IDLE, S_SCAN, S_FLUSH, S_VOTE, S_PICK, S_DONE} state_t;

  state_t             r_state, w_next;
  logic               w_accept, w_last;
  logic [CNT_W-1:0]   r_cnt;
  logic [DW-1:0]      r_qx, r_qy;
  logic               r_mode;
  logic [3:0]         r_keff, w_keff;
  logic               r_s1_valid, r_dist_valid;
  logic [DIST_W-1:0]  r_dist, w_dist;
  logic [CW-1:0]      r_dist_label;
  logic [DW:0]        w_dx, w_dy, w_ax, w_ay;
  logic [DIST_W-1:0]  r_buf_dist  [KMAX];
  logic [CW-1:0]      r_buf_label [KMAX];
  logic [KMAX-1:0]    r_buf_valid;
  logic [KMAX-1:0]    w_gt, w_here;
  logic [VW-1:0]      r_votes [NC];
  logic [IW-1:0]      w_vidx;
  logic [CW-1:0]      w_vlab, w_pc;
  logic [VW-1:0]      w_pv;
  logic [CW-1:0]      r_leader, w_leader;
  logic [VW-1:0]      r_best, w_best;
  logic               r_tie_acc, w_tie;
  logic [LAT_W-1:0]   r_lat_cnt, r_latency;
  logic               r_done, r_tie;
  logic [CW-1:0]      r_pred;

  assign o_busy       = (r_state == S_SCAN) || (r_state == S_FLUSH) ||
                        (r_state == S_VOTE) || (r_state == S_PICK);
  assign o_rom_addr   = (r_state == S_SCAN) ? r_cnt[AW-1:0] : '0;
  assign o_done       = r_done;
  assign o_pred_class = r_pred;
  assign o_tie        = r_tie;
  assign o_latency    = r_latency;

  // State register
  always_ff @(posedge i_clk) begin
    if (i_reset) r_state <= S_IDLE;
    else         r_state <= w_next;
  end

  // Next state; DONE accepts start too so runs can follow back-to-back
  always_comb begin
    w_next   = r_state;
    w_accept = 1'b0;
    w_last   = 1'b0;
    case (r_state)
      S_IDLE:  if (i_start) begin w_next = S_SCAN; w_accept = 1'b1; end
      S_SCAN:  begin
        w_last = (r_cnt == CNT_W'(N_POINTS - 1));
        if (w_last) w_next = S_FLUSH;
      end
      S_FLUSH: begin
        w_last = (r_cnt == CNT_W'(2));
        if (w_last) w_next = S_VOTE;
      end
      S_VOTE:  begin
        w_last = (r_cnt == CNT_W'(r_keff) - CNT_W'(1));
        if (w_last) w_next = S_PICK;
      end
      S_PICK:  begin
        w_last = (r_cnt == CNT_W'(NC - 1));
        if (w_last) w_next = S_DONE;
      end
      S_DONE:  begin
        if (i_start) begin w_next = S_SCAN; w_accept = 1'b1; end
        else         w_next = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  // Per-state cycle counter, restarts on every state change
  always_ff @(posedge i_clk) begin
    if (i_reset || (w_next != r_state) || !o_busy) r_cnt <= '0;
    else                                           r_cnt <= r_cnt + CNT_W'(1);
  end

  // Effective K: force odd and clamp to 1..KMAX
  always_comb begin
    if (i_k_sel == 4'd0)           w_keff = 4'd1;
    else if (i_k_sel > 4'(KMAX))   w_keff = 4'(KMAX);
    else if (!i_k_sel[0])          w_keff = i_k_sel - 4'd1;
    else                           w_keff = i_k_sel;
  end

  // Distance from the ROM word; magnitudes are DW+1 bits so nothing wraps
  always_comb begin
    w_dx = {r_qx[DW-1], r_qx} - {i_rom_x[DW-1], i_rom_x};
    w_dy = {r_qy[DW-1], r_qy} - {i_rom_y[DW-1], i_rom_y};
    w_ax = w_dx[DW] ? (~w_dx + ONE_D) : w_dx;
    w_ay = w_dy[DW] ? (~w_dy + ONE_D) : w_dy;
    if (r_mode) w_dist = DIST_W'(w_ax) * DIST_W'(w_ax) + DIST_W'(w_ay) * DIST_W'(w_ay);
    else        w_dist = DIST_W'(w_ax) + DIST_W'(w_ay);
  end

  // Query latch and read/distance pipeline
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_qx <= '0; r_qy <= '0; r_mode <= 1'b0; r_keff <= '0;
      r_s1_valid <= 1'b0; r_dist_valid <= 1'b0;
      r_dist <= '0; r_dist_label <= '0;
    end else begin
      r_s1_valid   <= (r_state == S_SCAN);
      r_dist_valid <= r_s1_valid;
      r_dist       <= w_dist;
      r_dist_label <= i_rom_label;
      if (w_accept) begin
        r_qx <= i_query_x; r_qy <= i_query_y;
        r_mode <= i_dist_mode; r_keff <= w_keff;
      end
    end
  end

  // Insert slot: first entry that is empty or strictly farther (equal keeps the older sample ahead)
  always_comb begin
    logic v_prev;
    v_prev = 1'b0;
    w_gt   = '0;
    w_here = '0;
    for (int j = 0; j < KMAX; j++) begin
      w_gt[j]   = !r_buf_valid[j] || (r_buf_dist[j] > r_dist);
      w_here[j] = w_gt[j] && !v_prev;
      v_prev    = w_gt[j];
    end
  end

  // Sorted top-K buffer: insert and shift the tail down
  always_ff @(posedge i_clk) begin
    if (i_reset || w_accept) begin
      r_buf_valid <= '0;
      for (int j = 0; j < KMAX; j++) begin
        r_buf_dist[j]  <= '0;
        r_buf_label[j] <= '0;
      end
    end else if (r_dist_valid) begin
      if (w_gt[0]) begin
        r_buf_dist[0] <= r_dist; r_buf_label[0] <= r_dist_label; r_buf_valid[0] <= 1'b1;
      end
      for (int j = 1; j < KMAX; j++) begin
        if (w_here[j]) begin
          r_buf_dist[j] <= r_dist; r_buf_label[j] <= r_dist_label; r_buf_valid[j] <= 1'b1;
        end else if (w_gt[j]) begin
          r_buf_dist[j]  <= r_buf_dist[j-1];
          r_buf_label[j] <= r_buf_label[j-1];
          r_buf_valid[j] <= r_buf_valid[j-1];
        end
      end
    end
  end

  // One argmax step: strictly greater replaces the leader, equal marks a tie
  always_comb begin
    w_vidx   = r_cnt[IW-1:0];
    w_vlab   = r_buf_label[w_vidx];
    w_pc     = r_cnt[CW-1:0];
    w_pv     = r_votes[w_pc];
    w_leader = r_leader;
    w_best   = r_best;
    w_tie    = r_tie_acc;
    if (r_cnt == '0) begin
      w_leader = '0; w_best = w_pv; w_tie = 1'b0;
    end else if (w_pv > r_best) begin
      w_leader = w_pc; w_best = w_pv; w_tie = 1'b0;
    end else if (w_pv == r_best) begin
      w_tie = 1'b1;
    end
  end

  // Vote tally over the first K_eff entries, then class scan
  always_ff @(posedge i_clk) begin
    if (i_reset || w_accept) begin
      for (int c = 0; c < NC; c++) r_votes[c] <= '0;
      r_leader <= '0; r_best <= '0; r_tie_acc <= 1'b0;
    end else if (r_state == S_VOTE) begin
      if (r_buf_valid[w_vidx]) r_votes[w_vlab] <= r_votes[w_vlab] + VW'(1);
    end else if (r_state == S_PICK) begin
      r_leader <= w_leader; r_best <= w_best; r_tie_acc <= w_tie;
    end
  end

  // Result registers and saturating latency counter
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_done <= 1'b0; r_pred <= '0; r_tie <= 1'b0;
      r_latency <= '0; r_lat_cnt <= '0;
    end else if (w_accept) begin
      r_done    <= 1'b0;
      r_lat_cnt <= LAT_W'(1);
    end else begin
      if (o_busy && (r_lat_cnt != '1)) r_lat_cnt <= r_lat_cnt + LAT_W'(1);
      if ((r_state == S_PICK) && w_last) begin
        r_done    <= 1'b1;
        r_pred    <= w_leader;
        r_tie     <= w_tie;
        r_latency <= (r_lat_cnt == '1) ? r_lat_cnt : r_lat_cnt + LAT_W'(1);
      end
    end
  end
endmodule

// File: tb/tb_knn_topk_engine.sv
// tb/tb_knn_topk_engine.sv - scoreboard bench for knn_topk_engine
module tb_knn_topk_engine;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       reset = 1'b1, start_a = 1'b0, start_b = 1'b0;
  logic [3:0] k_sel = 4'd0;
  logic       dist_mode = 1'b0;
  logic [7:0] q_x = 8'd0, q_y = 8'd0;
  logic [5:0] rom_addr_a, rom_addr_b;
  logic [7:0] rom_x_a, rom_y_a, rom_x_b, rom_y_b;
  logic [0:0] rom_lab_a, pred_a;
  logic [1:0] rom_lab_b, pred_b;
  logic       busy_a, done_a, tie_a, busy_b, done_b, tie_b;
  logic [7:0] lat_a, lat_b;

  int n_vec = 0, n_fail = 0, cyc = 0, n_done_a = 0;
  bit extreme = 1'b0;
  logic prev_done_a = 1'b0;

  typedef struct {int pred; int tie; int lat; int t0;} exp_t;
  exp_t sbq[$];
  exp_t m_e;

  knn_topk_engine #(.CW(1)) dut_a (
    .i_clk(clk), .i_reset(reset), .i_start(start_a), .i_k_sel(k_sel), .i_dist_mode(dist_mode),
    .i_query_x(q_x), .i_query_y(q_y), .o_rom_addr(rom_addr_a), .i_rom_x(rom_x_a), .i_rom_y(rom_y_a),
    .i_rom_label(rom_lab_a), .o_busy(busy_a), .o_done(done_a), .o_pred_class(pred_a),
    .o_tie(tie_a), .o_latency(lat_a));

  knn_topk_engine #(.CW(2)) dut_b (
    .i_clk(clk), .i_reset(reset), .i_start(start_b), .i_k_sel(k_sel), .i_dist_mode(dist_mode),
    .i_query_x(q_x), .i_query_y(q_y), .o_rom_addr(rom_addr_b), .i_rom_x(rom_x_b), .i_rom_y(rom_y_b),
    .i_rom_label(rom_lab_b), .o_busy(busy_b), .o_done(done_b), .o_pred_class(pred_b),
    .o_tie(tie_b), .o_latency(lat_b));

  function automatic logic [7:0] rx(int i);
    if (extreme && i == 0) return 8'h80;
    return (i < 32) ? 8'h10 + 8'(i % 3) : 8'hF0 - 8'(i % 3);
  endfunction
  function automatic logic [7:0] ry(int i);
    if (extreme && i == 0) return 8'h80;
    return (i < 32) ? 8'h10 - 8'(i % 3) : 8'hF0 + 8'(i % 3);
  endfunction
  function automatic int rl(int i);
    return (i < 32) ? 1 : 0;
  endfunction

  function automatic logic [7:0] bx(int i);
    case (i) 0: return 8'd2; 1: return 8'd4; 2: return 8'd0; default: return 8'h40; endcase
  endfunction
  function automatic logic [7:0] by(int i);
    case (i) 0: return 8'd2; 1: return 8'd0; 2: return 8'd4; default: return 8'h40; endcase
  endfunction
  function automatic logic [1:0] bl(int i);
    case (i) 0: return 2'd3; 1: return 2'd2; 2: return 2'd1; default: return 2'd0; endcase
  endfunction

  // synchronous ROMs: data one cycle after address
  always @(posedge clk) begin
    rom_x_a   <= rx(int'(rom_addr_a));
    rom_y_a   <= ry(int'(rom_addr_a));
    rom_lab_a <= 1'(rl(int'(rom_addr_a)));
    rom_x_b   <= bx(int'(rom_addr_b));
    rom_y_b   <= by(int'(rom_addr_b));
    rom_lab_b <= bl(int'(rom_addr_b));
  end

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic int keff(int k);
    if (k == 0) return 1;
    if (k > 7) return 7;
    if (k % 2 == 0) return k - 1;
    return k;
  endfunction

  // reference: pick K_eff nearest by repeated minimum search, lowest index wins ties
  function automatic void model_a(input int qx, input int qy, input int k, input bit mode,
                                  output int pred, output int tie);
    int d[64];
    bit used[64];
    int votes[2];
    int ke, best, dx, dy;
    votes = '{0, 0};
    ke = keff(k);
    for (int i = 0; i < 64; i++) begin
      used[i] = 1'b0;
      dx = qx - int'($signed(rx(i)));
      dy = qy - int'($signed(ry(i)));
      d[i] = mode ? dx * dx + dy * dy : (dx < 0 ? -dx : dx) + (dy < 0 ? -dy : dy);
    end
    for (int s = 0; s < ke; s++) begin
      best = -1;
      for (int i = 0; i < 64; i++)
        if (!used[i] && (best < 0 || d[i] < d[best])) best = i;
      used[best] = 1'b1;
      votes[rl(best)]++;
    end
    pred = (votes[1] > votes[0]) ? 1 : 0;
    tie  = (votes[1] == votes[0]) ? 1 : 0;
  endfunction

  function automatic int exp_lat(int k);
    int l;
    l = 64 + 4 + keff(k) + 2;
    return (l > 255) ? 255 : l;
  endfunction

  task automatic push_exp(input logic [7:0] qx, input logic [7:0] qy, input int k, input bit mode);
    int p, t;
    model_a(int'($signed(qx)), int'($signed(qy)), k, mode, p, t);
    sbq.push_back('{p, t, exp_lat(k), cyc});
  endtask

  task automatic start_a_run(input logic [7:0] qx, input logic [7:0] qy, input logic [3:0] k,
                             input bit mode, input bit hold);
    @(negedge clk);
    q_x = qx; q_y = qy; k_sel = k; dist_mode = mode; start_a = 1'b1;
    push_exp(qx, qy, int'(k), mode);
    if (!hold) begin
      @(negedge clk);
      start_a = 1'b0;
    end
  endtask

  task automatic wait_done_a(input int target, input int budget);
    int c;
    c = 0;
    while (n_done_a < target && c < budget) begin
      @(negedge clk);
      c++;
    end
    check("done_count", 64'(n_done_a), 64'(target));
  endtask

  // scoreboard monitor on done rise
  always @(negedge clk) begin
    if (done_a && !prev_done_a) begin
      n_done_a++;
      if (sbq.size() == 0) check("unexpected_done", 64'(1), 64'(0));
      else begin
        m_e = sbq.pop_front();
        check("pred", 64'(pred_a), 64'(m_e.pred));
        check("tie", 64'(tie_a), 64'(m_e.tie));
        check("latency", 64'(lat_a), 64'(m_e.lat));
        check("done_cycle", 64'(cyc - m_e.t0), 64'(m_e.lat));
      end
    end
    prev_done_a = done_a;
  end

  initial begin
    int base, c, t0;
    repeat (3) @(negedge clk);
    check("rst_busy", 64'(busy_a), 64'(0));
    check("rst_done", 64'(done_a), 64'(0));
    check("rst_lat", 64'(lat_a), 64'(0));
    check("rst_addr", 64'(rom_addr_a), 64'(0));
    reset = 1'b0;

    // basic queries and K selection
    start_a_run(8'h12, 8'h0F, 4'd3, 1'b0, 1'b0); wait_done_a(1, 200);
    start_a_run(8'h12, 8'h0F, 4'd5, 1'b1, 1'b0); wait_done_a(2, 200);
    start_a_run(8'h12, 8'h0F, 4'd4, 1'b0, 1'b0); wait_done_a(3, 200);
    start_a_run(8'h12, 8'h0F, 4'd0, 1'b0, 1'b0); wait_done_a(4, 200);
    start_a_run(8'h12, 8'h0F, 4'd12, 1'b1, 1'b0); wait_done_a(5, 200);
    start_a_run(8'hF0, 8'hF0, 4'd3, 1'b0, 1'b0); wait_done_a(6, 200);
    start_a_run(8'hF0, 8'hF0, 4'd3, 1'b1, 1'b0); wait_done_a(7, 200);

    // start pulse and input change during SCAN are ignored
    base = n_done_a;
    start_a_run(8'hF0, 8'hF0, 4'd3, 1'b0, 1'b0);
    repeat (9) @(negedge clk);
    q_x = 8'h12; q_y = 8'h0F; k_sel = 4'd5; dist_mode = 1'b1; start_a = 1'b1;
    @(negedge clk); start_a = 1'b0;
    wait_done_a(base + 1, 200);
    repeat (100) @(negedge clk);
    check("single_done", 64'(n_done_a), 64'(base + 1));

    // held start: back-to-back runs
    base = n_done_a;
    start_a_run(8'hF0, 8'hF0, 4'd3, 1'b0, 1'b1);
    @(negedge clk);
    c = 0;
    while (!done_a && c < 200) begin @(negedge clk); c++; end
    check("b2b_first_done", 64'(done_a), 64'(1));
    push_exp(8'hF0, 8'hF0, 3, 1'b0);
    @(negedge clk); start_a = 1'b0;
    wait_done_a(base + 2, 200);

    // reset mid-run kills the result
    start_a_run(8'h12, 8'h0F, 4'd3, 1'b0, 1'b0); wait_done_a(base + 3, 200);
    base = n_done_a;
    start_a_run(8'h12, 8'h0F, 4'd3, 1'b0, 1'b0);
    repeat (19) @(negedge clk);
    reset = 1'b1;
    sbq.delete();
    @(negedge clk);
    check("mid_rst_busy", 64'(busy_a), 64'(0));
    check("mid_rst_done", 64'(done_a), 64'(0));
    check("mid_rst_pred", 64'(pred_a), 64'(0));
    check("mid_rst_tie", 64'(tie_a), 64'(0));
    check("mid_rst_lat", 64'(lat_a), 64'(0));
    check("mid_rst_addr", 64'(rom_addr_a), 64'(0));
    reset = 1'b0;
    repeat (100) @(negedge clk);
    check("no_done_after_rst", 64'(n_done_a), 64'(base));
    start_a_run(8'h12, 8'h0F, 4'd3, 1'b0, 1'b0); wait_done_a(base + 1, 200);

    // extreme distances
    extreme = 1'b1;
    base = n_done_a;
    start_a_run(8'h7F, 8'h7F, 4'd3, 1'b1, 1'b0);
    c = 0;
    while (!dut_a.r_dist_valid && c < 20) begin @(negedge clk); c++; end
    check("sq_dist_valid", 64'(dut_a.r_dist_valid), 64'(1));
    check("sq_dist", 64'(dut_a.r_dist), 64'(130050));
    wait_done_a(base + 1, 200);
    start_a_run(8'h7F, 8'h7F, 4'd3, 1'b0, 1'b0);
    c = 0;
    while (!dut_a.r_dist_valid && c < 20) begin @(negedge clk); c++; end
    check("man_dist", 64'(dut_a.r_dist), 64'(510));
    wait_done_a(base + 2, 200);
    extreme = 1'b0;

    // four-class vote tie
    @(negedge clk);
    q_x = 8'd0; q_y = 8'd0; k_sel = 4'd3; dist_mode = 1'b0; start_b = 1'b1;
    t0 = cyc;
    @(negedge clk); start_b = 1'b0;
    c = 0;
    while (!done_b && c < 200) begin @(negedge clk); c++; end
    check("b_done", 64'(done_b), 64'(1));
    check("b_pred", 64'(pred_b), 64'(1));
    check("b_tie", 64'(tie_b), 64'(1));
    check("b_lat", 64'(lat_b), 64'(75));
    check("b_cycle", 64'(cyc - t0), 64'(75));
    check("b_buf0", 64'(dut_b.r_buf_label[0]), 64'(3));
    check("b_buf1", 64'(dut_b.r_buf_label[1]), 64'(2));
    check("b_buf2", 64'(dut_b.r_buf_label[2]), 64'(1));

    repeat (5) @(negedge clk);
    check("sb_empty", 64'(sbq.size()), 64'(0));
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end
endmodule

// File: doc/knn_topk_engine.md
# knn_topk_engine

Parametrised k-nearest-neighbour classifier core: second-generation engine behind `top`. It streams a training set from an external synchronous ROM and keeps a sorted top-K buffer of nearest samples. It then majority-votes over 2**CW classes and reports the class and the cycle latency. Compared with the fixed K=3/5, 2-class engine, it adds runtime-selectable odd K up to KMAX, Manhattan or squared-Euclidean distance, multi-class labels, and a vote-tie flag.

## Interface
- DW, 8, feature width; signed two's-complement Q4.4 (x, y).
- N_POINTS, 64, training samples in ROM.
- AW, 6, ROM address width; must satisfy 2**AW >= N_POINTS.
- KMAX, 7, top-K buffer depth; odd, >= 1.
- CW, 1, class label width; NUM_CLASSES = 2**CW.
- LAT_W, 8, latency counter width.
- clk  in  1  single clock, rising edge.
- reset  in  1  synchronous, active-high.
- start  in  1  level; sampled only in IDLE.
- k_sel  in  4  requested K, sampled at start.
- dist_mode  in  1  0 = Manhattan, 1 = squared Euclidean; sampled at start.
- query_x, query_y  in  DW each  query point; sampled at start.
- rom_addr  out  AW  training-sample address.
- rom_x, rom_y  in  DW each  sample features; valid the cycle after rom_addr.
- rom_label  in  CW  sample class; valid the cycle after rom_addr.
- busy  out  1  high while a classification is in flight.
- done  out  1  level; high from completion until the next accepted start.
- pred_class  out  CW  winning class.
- tie  out  1  top vote count shared by more than one class.
- latency  out  LAT_W  cycles from start sample to done rise; saturating.

## Operation
- Effective K (K_eff) is computed at start:
  - k_sel = 0 -> 1.
  - k_sel > KMAX -> KMAX.
  - Even k_sel -> k_sel - 1.
  - K_eff is held for the whole run.
- Distances:
  - dx = query_x - rom_x and dy = query_y - rom_y, sign-extended to DW+1 bits.
  - Manhattan: |dx| + |dy|.
  - Squared Euclidean: dx*dx + dy*dy.
  - Both are zero-extended to DIST_W = 2*DW+3 bits. No truncation is permitted.
- Top-K buffer:
  - KMAX entries of {dist, label, valid}, sorted ascending. All entries are cleared at start.
  - A new sample is inserted before the first entry that is invalid or has dist strictly greater than the new dist. Lower entries shift down and the last entry drops.
  - On equal distance, the lower ROM index stays nearer.
- Vote:
  - Only entries 0..K_eff-1 are tallied; invalid entries are skipped.
  - Argmax runs over classes in ascending index. A strictly greater count replaces the leader, so ties resolve to the lowest class index.
  - tie = 1 if any later class equals the final leader count.
- FSM, one state register:
  - IDLE: start=1 -> SCAN. Latches K_eff, dist_mode and the query; clears the buffer, done, tie and the latency counter.
  - SCAN: N_POINTS cycles. rom_addr = 0..N_POINTS-1, one address per cycle.
  - FLUSH: 3 cycles. Drains the pipeline of ROM read, distance register and insert.
  - VOTE: K_eff cycles, one buffer entry tallied per cycle.
  - PICK: NUM_CLASSES cycles, one class compared per cycle.
  - DONE: drives done=1, updates pred_class, tie and latency, then -> IDLE. done stays high in IDLE.
- start while busy is ignored. Input changes while busy are ignored.
- rom_addr holds 0 outside SCAN.

## Timing
- Reset (any state, including mid-SCAN) gives IDLE and all of the following at 0: busy, done, pred_class, tie, latency, rom_addr, the buffer and the counters. No in-flight result survives.
- Pipeline for sample i:
  - Address driven in cycle a.
  - Data valid in cycle a+1.
  - Distance registered at the end of a+1.
  - Buffer insert at the end of a+2.
- For start sampled in cycle T:
  - busy=1 and done=0 from T+1.
  - done rises in cycle T+L with L = N_POINTS + 4 + K_eff + NUM_CLASSES.
  - busy falls in the same cycle done rises.
  - latency = L, saturating at 2**LAT_W-1.
- pred_class, tie and latency hold their values until the next done rise. They do not change when start is accepted.
- If start is held high in IDLE with done=1, the next run begins immediately. Re-arm is back-to-back: start in the cycle done is high is accepted.

## Test plan
Bench ROM, shared by all scenarios: samples 0..31 have label 1 at (0x10+i%3, 0x10-i%3); samples 32..63 have label 0 at (0xF0-i%3, 0xF0+i%3). Defaults apply (CW=1).

1. Query (0x12, 0x0F), k_sel=3, dist_mode=0 -> pred_class=1, tie=0, latency=73; done rises exactly 73 cycles after the start sample.
2. Same query, k_sel=5 and dist_mode=1 -> pred_class=1, latency=75. Separately, k_sel=4 -> K_eff=3 and latency=73; k_sel=0 -> latency=71; k_sel=12 -> latency=77.
3. Query (0xF0, 0xF0), k_sel=3, both distance modes -> pred_class=0. Also check the start pulse behaviour:
   - A start pulse during SCAN is ignored: one done, latency unchanged.
   - Holding start high gives back-to-back runs.
4. Tie, with CW=2 and a ROM in which samples 0, 1 and 2 carry labels 3, 2 and 1 at equal distance 0x04 and all other samples are farther; k_sel=3 -> pred_class=1, tie=1. The equal-distance ordering in the buffer is indices 0, 1, 2.
5. Assert reset for one cycle at cycle T+20 of a run -> outputs all 0 from the next cycle and no done. A fresh start then gives a correct result and latency=73.
6. Extreme query (0x7F, 0x7F) against a sample at (0x80, 0x80), dist_mode=1 -> the registered distance equals 2*255*255 = 130050 with no overflow; Manhattan gives 510.
